// File: rtl/halflife_sequencer_if.sv
// Request/control inputs and counter-strobe/status outputs of halflife_sequencer.
// The requester drives through the master modport; the sequencer uses slave.
interface halflife_sequencer_if #(
  parameter int unsigned PERIOD_W = 8
);
  logic                start;
  logic                abort;
  logic [3:0]          init_val;
  logic [PERIOD_W-1:0] period;
  logic                man_up;
  logic                man_down;
  logic                ctr_load;
  logic [3:0]          ctr_data;
  logic                ctr_up;
  logic                ctr_down;
  logic [3:0]          remaining;
  logic                busy;
  logic                done;
  logic [1:0]          state;

  modport master (
    output start, abort, init_val, period, man_up, man_down,
    input  ctr_load, ctr_data, ctr_up, ctr_down, remaining, busy, done, state
  );

  modport slave (
    input  start, abort, init_val, period, man_up, man_down,
    output ctr_load, ctr_data, ctr_up, ctr_down, remaining, busy, done, state
  );
endinterface

// File: rtl/halflife_sequencer.sv
// Decay sequencer: loads a counter, steps it down every `period` clocks, pulses done.
// Define HALFLIFE_SEQ_AUTORELOAD_EN to make DONE reload and repeat until abort.
module halflife_sequencer #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  halflife_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] presc_q;
  logic [PERIOD_W-1:0] presc_max;
  logic [3:0]          rem_q;
  logic [3:0]          data_q;
  logic                load_q;
  logic                up_q;
  logic                down_q;
  logic                busy_q;
  logic                done_q;

  always_comb begin
    presc_max = bus.period - PERIOD_W'(1);
    if (bus.period == '0) presc_max = '0;
  end

  // data_q only changes on a load, so it doubles as the latched init_val for reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        presc_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q <= LOAD;
              data_q  <= bus.init_val;
              rem_q   <= bus.init_val;
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else if (bus.man_up && !bus.man_down) begin
              up_q  <= 1'b1;
              rem_q <= rem_q + 4'd1;
            end else if (bus.man_down && !bus.man_up) begin
              down_q <= 1'b1;
              rem_q  <= rem_q - 4'd1;
            end
          end
          LOAD: begin
            state_q <= RUN;
            presc_q <= '0;
          end
          RUN: begin
            if (rem_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (presc_q == presc_max) begin
              presc_q <= '0;
              down_q  <= 1'b1;
              rem_q   <= rem_q - 4'd1;
            end else begin
              presc_q <= presc_q + PERIOD_W'(1);
            end
          end
          DONE: begin
`ifdef HALFLIFE_SEQ_AUTORELOAD_EN
            state_q <= LOAD;
            rem_q   <= data_q;
            load_q  <= 1'b1;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.ctr_load  = load_q;
  assign bus.ctr_data  = data_q;
  assign bus.ctr_up    = up_q;
  assign bus.ctr_down  = down_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: doc/halflife_sequencer.md
HALFLIFE_SEQUENCER -- requirements
Module: halflife_sequencer

Interface
REQ-001 Parameter PERIOD_W, default 8: width of the step-period input and the internal prescaler.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level-sampled request to begin a decay sequence.
REQ-005 abort  input  1  level-sampled request to terminate any activity.
REQ-006 init_val  input  4  count value loaded into the counter at sequence start.
REQ-007 period  input  PERIOD_W  clk cycles between decay steps; value 0 behaves as 1.
REQ-008 man_up  input  1  manual increment request.
REQ-009 man_down  input  1  manual decrement request.
REQ-010 ctr_load  output  1  load strobe to the counter.
REQ-011 ctr_data  output  4  load data to the counter.
REQ-012 ctr_up  output  1  increment strobe to the counter.
REQ-013 ctr_down  output  1  decrement strobe to the counter.
REQ-014 remaining  output  4  shadow copy of the expected counter value.
REQ-015 busy  output  1  high in states LOAD, RUN and DONE.
REQ-016 done  output  1  one-cycle pulse at sequence completion.
REQ-017 state  output  2  encoding: IDLE=0, LOAD=1, RUN=2, DONE=3.

Function
REQ-018 All outputs SHALL be registered; ctr_load, ctr_up and ctr_down SHALL be single-cycle pulses and SHALL never be high together.
REQ-019 Input priority SHALL be: abort, then start, then manual requests.
REQ-020 IDLE: start=1 SHALL move the FSM to LOAD on the next edge; man_up or man_down alone SHALL produce a ctr_up or ctr_down pulse one cycle later; man_up and man_down together SHALL produce no pulse.
REQ-021 Manual ctr_up SHALL increment remaining modulo 16 (15 wraps to 0); manual ctr_down SHALL decrement remaining modulo 16 (0 wraps to 15).
REQ-022 LOAD: the FSM SHALL hold for one cycle with ctr_load=1 and ctr_data=init_val (sampled when start was accepted), SHALL set remaining=init_val, and SHALL then move to RUN with the prescaler at 0.
REQ-023 RUN: the prescaler SHALL increment each cycle; when it reaches max(period,1)-1 it SHALL clear to 0 and ctr_down SHALL pulse on the following cycle, decrementing remaining.
REQ-024 RUN: when remaining==0 the FSM SHALL move to DONE without issuing a further ctr_down; init_val=0 therefore yields LOAD, one RUN cycle, then DONE.
REQ-025 A change to period during RUN SHALL take effect at the next prescaler comparison.
REQ-026 DONE: done SHALL be 1 for exactly one cycle, after which the FSM moves to IDLE (see REQ-032).
REQ-027 start, man_up and man_down SHALL be ignored outside IDLE.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge, clear the prescaler, suppress all strobes and done in that cycle, and leave remaining unchanged.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, prescaler=0 and remaining=0, and drive ctr_load, ctr_up, ctr_down, busy and done to 0 and ctr_data to 0.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
REQ-031 After rst_n deasserts, the first edge SHALL sample inputs normally.

Configuration
REQ-032 With macro HALFLIFE_SEQ_AUTORELOAD_EN defined, DONE SHALL move to LOAD (re-using the latched init_val) instead of IDLE, repeating until abort; without the macro DONE SHALL always move to IDLE.

Verification
REQ-033 Sequence: reset, init_val=3, period=2, start pulse -> ctr_load one cycle after start with ctr_data=3; three ctr_down pulses 2 cycles apart; remaining reaches 0; one done pulse; state returns to 0.
REQ-034 Zero load: init_val=0, period=5, start -> ctr_load, no ctr_down, done pulse within 3 cycles of ctr_load.
REQ-035 Manual wrap: IDLE with remaining=15, man_up -> ctr_up pulse, remaining=0; man_up and man_down together -> no strobe.
REQ-036 Abort: abort at the 2nd RUN cycle with init_val=9 -> state=0 next cycle, no done, no further strobes, remaining held.
REQ-037 Period 0: init_val=2, period=0 -> ctr_down pulses on consecutive cycles, identical to period=1.
REQ-038 Autoreload (macro defined): init_val=1, period=1 -> ctr_load, ctr_down, done repeating until abort; a reset mid-RUN clears all outputs immediately.
